// File: rtl/tt_um_chip_sp_phrase_rx_if.sv
// Pin bundle for the phrase receiver: the sender drives the inputs,
// the receiver drives the status/pulse outputs.
interface tt_um_chip_sp_phrase_rx_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_chip_sp_phrase_rx.sv
// Strobed ASCII phrase matcher ("Guatemala" / "Quetzal") with a
// wrapping match counter and one-cycle match/error pulses.
module tt_um_chip_sp_phrase_rx #(
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [2:0]       s_q, s_d;
    logic             sel_q, sel_d;
    logic             selp_q, selp_d;
    logic [3:0]       pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mat_q, mat_d;
    logic             err_q, err_d;

    logic             chg;
    logic             acc;
    logic [3:0]       pos_e;
    logic [3:0]       last;
    logic [CNT_W+3:0] cnt_x;
    logic [4:0]       unused_uio;

    // sel = 1 selects "Quetzal", 0 selects "Guatemala"
    function automatic logic [7:0] phr_chr(input logic sel, input logic [3:0] i);
        logic [7:0] c;
        c = 8'h00;
        if (sel) begin
            case (i)
                4'd0:    c = 8'h51;
                4'd1:    c = 8'h75;
                4'd2:    c = 8'h65;
                4'd3:    c = 8'h74;
                4'd4:    c = 8'h7A;
                4'd5:    c = 8'h61;
                4'd6:    c = 8'h6C;
                default: c = 8'h00;
            endcase
        end else begin
            case (i)
                4'd0:    c = 8'h47;
                4'd1:    c = 8'h75;
                4'd2:    c = 8'h61;
                4'd3:    c = 8'h74;
                4'd4:    c = 8'h65;
                4'd5:    c = 8'h6D;
                4'd6:    c = 8'h61;
                4'd7:    c = 8'h6C;
                4'd8:    c = 8'h61;
                default: c = 8'h00;
            endcase
        end
        return c;
    endfunction

    always_comb begin
        s_d    = {s_q[1:0], uio_in[0]};
        sel_d  = sel_q;
        selp_d = selp_q;
        pos_d  = pos_q;
        cnt_d  = cnt_q;
        mat_d  = 1'b0;
        err_d  = 1'b0;
        chg    = sel_q ^ selp_q;
        acc    = s_q[1] & ~s_q[2] & ena;
        pos_e  = chg ? 4'd0 : pos_q;
        last   = sel_q ? 4'd6 : 4'd8;
        if (ena) begin
            sel_d  = uio_in[2] ^ uio_in[1];
            selp_d = sel_q;
            pos_d  = pos_e;
            if (acc) begin
                if (ui_in == phr_chr(sel_q, pos_e)) begin
                    if (pos_e == last) begin
                        mat_d = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                        pos_d = 4'd0;
                    end else begin
                        pos_d = pos_e + 4'd1;
                    end
                end else begin
                    // no phrase repeats its first char, so restart is exact
                    pos_d = (ui_in == phr_chr(sel_q, 4'd0)) ? 4'd1 : 4'd0;
                    err_d = (pos_e != 4'd0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q    <= '0;
            sel_q  <= 1'b0;
            selp_q <= 1'b0;
            pos_q  <= '0;
            cnt_q  <= '0;
            mat_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            sel_q  <= sel_d;
            selp_q <= selp_d;
            pos_q  <= pos_d;
            cnt_q  <= cnt_d;
            mat_q  <= mat_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        cnt_x      = {4'b0000, cnt_q};
        uo_out     = {cnt_x[3:0], pos_q};
        uio_out    = {2'b00, (pos_q != 4'd0), err_q, mat_q, 3'b000};
        uio_oe     = 8'b1111_1000;
        unused_uio = uio_in[7:3];
    end

endmodule

// File: doc/tt_um_chip_sp_phrase_rx.md
# tt_um_chip_sp_phrase_rx

Receive-side phrase matcher for the chip's ASCII character stream. A sender presents one ASCII byte per strobe. The block tracks progress through a selectable reference phrase, "Guatemala" or "Quetzal", and counts complete matches. Status appears on the dedicated outputs, and pulses appear on the bidirectional pins.

## Interface
Parameters:
- CNT_W, default 4: width of the match counter, which wraps modulo 2^CNT_W.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  synchronous active-low reset
- ena  in  1  high = design enabled; low = all state holds, strobes ignored
- ui_in  in  8  ASCII data byte; must be stable from strobe rise to strobe fall
- uo_out  out  8  [3:0] = current match position (0..8); [7:4] = match counter
- uio_in  in  8  [0] = data strobe (asynchronous, level); [2:1] = phrase select; [7:3] ignored
- uio_out  out  8  [3] = match pulse; [4] = error pulse; [5] = busy; [7:6] and [2:0] = 0
- uio_oe  out  8  constant 8'b1111_1000

## Operation
- Phrase select (uio_in[2:1]):
  - 00 or 11: "Guatemala", 9 chars: 0x47 75 61 74 65 6D 61 6C 61.
  - 01 or 10: "Quetzal", 7 chars: 0x51 75 65 74 7A 61 6C.
  - LEN is 9 or 7 accordingly.
- Strobe path:
  - uio_in[0] passes through a 3-flop chain s1→s2→s3.
  - accept = s2 & ~s3, one cycle per strobe rising edge.
  - ui_in is sampled directly on the accept cycle.
- Position register pos (4 bits) holds the index of the next expected char. On accept, with byte b:
  - b == phrase[pos] and pos == LEN-1:
    - match pulse = 1 for one cycle
    - counter += 1, wrapping at 2^CNT_W
    - pos ← 0
  - b == phrase[pos] and pos < LEN-1: pos ← pos+1.
  - b != phrase[pos]:
    - pos ← 1 if b == phrase[0], else pos ← 0.
    - The error pulse fires only if the old pos != 0.
    - This restart rule is exact because neither phrase repeats its first char.
- Phrase select change:
  - Select is registered each cycle.
  - When the registered value's phrase differs from the previous one, pos ← 0 on that edge. The counter holds and no pulses fire.
  - An accept on the same cycle is evaluated against the new phrase from pos 0.
  - 00↔11 and 01↔10 are not changes.
- busy = (pos != 0).
- ena low:
  - The sync chain still shifts, but accept is masked.
  - pos, counter, and pulses hold, with pulses forced 0.
  - A strobe edge arriving while ena is low is lost.
- Reset (rst_n low at a rising edge) clears all of the following:
  - s1..s3, pos, counter, registered select, and pulses.
  - Resulting outputs: uo_out = 0x00; uio_out = 0x00; uio_oe = 0xF8.
  - Reset mid-phrase discards progress.

## Timing
- Strobe rise first sampled at edge E0 into s1. s2 = 1 after E1. accept is high during the cycle after E1.
- pos, counter, and pulses update at E2. Pulses are visible for exactly the one cycle after E2.
- Latency: 3 rising edges from strobe rise to visible result.
- Sender requirements:
  - Strobe high ≥ 3 cycles and low ≥ 3 cycles.
  - ui_in stable from the strobe rise until after E2.
- Throughput: 1 byte per 6 cycles max.
- Match and error pulses are mutually exclusive in any cycle.
- The counter increments on the same edge the match pulse asserts.
- Counter wrap: 0xF + 1 → 0x0 (CNT_W = 4), with no flag.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset check: reset, select 00 → uo_out = 0x00, uio_out = 0x00, uio_oe = 0xF8.
- Clean match: select 00, strobe 0x47 75 61 74 65 6D 61 6C 61 → pos steps 1..8, then 0. Match pulse fires once, 3 edges after the last strobe rise. uo_out = 0x10.
- Mismatch restart: select 01, send 0x51 75 51 75 65 74 7A 61 6C.
  - The third byte (0x51) gives an error pulse and pos = 1.
  - The sequence ends with a match pulse and counter = 1.
  - No error pulse fires on a first-byte mismatch from pos 0.
- Mid-phrase select change: select 00, send 0x47 75 61 (pos = 3), then switch to 10 → pos = 0 and counter unchanged. Then send full "Quetzal" → match, counter = 1.
- Counter wrap: select 00, send 16 complete phrases → 16 match pulses; uo_out[7:4] goes 0xF → 0x0.
- ena/reset interruption:
  - ena low during a strobe → no update.
  - rst_n low after 0x47 75 → pos = 0, counter = 0; the next full phrase matches normally.
